// File: rtl/shared_reg_access_ctrl.sv
// RT/GP access arbiter for the shared register file.
// Serializes same-address write conflicts with a GP starvation guard.
module shared_reg_access_ctrl #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rt_req_valid,
  output logic        rt_req_ready,
  input  logic        rt_req_we,
  input  logic [2:0]  rt_req_addr,
  input  logic [31:0] rt_req_wdata,
  output logic        rt_resp_valid,
  output logic [31:0] rt_resp_rdata,
  input  logic        gp_req_valid,
  output logic        gp_req_ready,
  input  logic        gp_req_we,
  input  logic [2:0]  gp_req_addr,
  input  logic [31:0] gp_req_wdata,
  output logic        gp_resp_valid,
  output logic [31:0] gp_resp_rdata,
  output logic        srf_rt_en,
  output logic        srf_rt_we,
  output logic [2:0]  srf_rt_addr,
  output logic [31:0] srf_rt_wdata,
  input  logic [31:0] srf_rt_rdata,
  output logic        srf_gp_en,
  output logic        srf_gp_we,
  output logic [2:0]  srf_gp_addr,
  output logic [31:0] srf_gp_wdata,
  input  logic [31:0] srf_gp_rdata,
  output logic [15:0] conflict_count
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic       init_done;
  logic [3:0] starve_cnt;
  logic       conflict;
  logic       gp_wins;
  logic       rt_grant;
  logic       gp_grant;

  always_comb begin
    conflict = rt_req_valid && gp_req_valid &&
               (rt_req_addr == gp_req_addr) &&
               (rt_req_we || gp_req_we);
    gp_wins = conflict && (starve_cnt == LIMIT);

    rt_req_ready = init_done && !gp_wins;
    gp_req_ready = init_done && !(conflict && !gp_wins);

    rt_grant = rt_req_valid && rt_req_ready;
    gp_grant = gp_req_valid && gp_req_ready;
  end

  // Ungranted ports drive all-zero so the file sees no stray traffic.
  always_comb begin
    srf_rt_en    = rt_grant;
    srf_rt_we    = rt_grant && rt_req_we;
    srf_rt_addr  = rt_grant ? rt_req_addr : '0;
    srf_rt_wdata = rt_grant ? rt_req_wdata : '0;
    srf_gp_en    = gp_grant;
    srf_gp_we    = gp_grant && gp_req_we;
    srf_gp_addr  = gp_grant ? gp_req_addr : '0;
    srf_gp_wdata = gp_grant ? gp_req_wdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_done <= 1'b0;
    end else begin
      init_done <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (gp_grant) begin
      starve_cnt <= '0;
    end else if (conflict && init_done &&
                 starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_count <= '0;
    end else if (conflict && init_done &&
                 conflict_count != 16'hFFFF) begin
      conflict_count <= conflict_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rt_resp_valid <= 1'b0;
      rt_resp_rdata <= '0;
      gp_resp_valid <= 1'b0;
      gp_resp_rdata <= '0;
    end else begin
      rt_resp_valid <= rt_grant;
      gp_resp_valid <= gp_grant;
      if (rt_grant) begin
        rt_resp_rdata <= rt_req_we ? '0 : srf_rt_rdata;
      end
      if (gp_grant) begin
        gp_resp_rdata <= gp_req_we ? '0 : srf_gp_rdata;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_access_ctrl.sv
// Scoreboard bench for shared_reg_access_ctrl with a behavioural
// register file model attached to both srf ports.
module tb_shared_reg_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rt_req_valid, rt_req_ready, rt_req_we;
  logic [2:0]  rt_req_addr;
  logic [31:0] rt_req_wdata;
  logic        rt_resp_valid;
  logic [31:0] rt_resp_rdata;
  logic        gp_req_valid, gp_req_ready, gp_req_we;
  logic [2:0]  gp_req_addr;
  logic [31:0] gp_req_wdata;
  logic        gp_resp_valid;
  logic [31:0] gp_resp_rdata;
  logic        srf_rt_en, srf_rt_we;
  logic [2:0]  srf_rt_addr;
  logic [31:0] srf_rt_wdata, srf_rt_rdata;
  logic        srf_gp_en, srf_gp_we;
  logic [2:0]  srf_gp_addr;
  logic [31:0] srf_gp_wdata, srf_gp_rdata;
  logic [15:0] conflict_count;

  int checks = 0;
  int errors = 0;
  int exp_cc = 0;

  logic [31:0] regs [8];
  logic [31:0] rt_q [$];
  logic [31:0] gp_q [$];

  always #5 clk = ~clk;

  shared_reg_access_ctrl #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .rt_req_valid(rt_req_valid), .rt_req_ready(rt_req_ready),
    .rt_req_we(rt_req_we), .rt_req_addr(rt_req_addr),
    .rt_req_wdata(rt_req_wdata),
    .rt_resp_valid(rt_resp_valid), .rt_resp_rdata(rt_resp_rdata),
    .gp_req_valid(gp_req_valid), .gp_req_ready(gp_req_ready),
    .gp_req_we(gp_req_we), .gp_req_addr(gp_req_addr),
    .gp_req_wdata(gp_req_wdata),
    .gp_resp_valid(gp_resp_valid), .gp_resp_rdata(gp_resp_rdata),
    .srf_rt_en(srf_rt_en), .srf_rt_we(srf_rt_we),
    .srf_rt_addr(srf_rt_addr), .srf_rt_wdata(srf_rt_wdata),
    .srf_rt_rdata(srf_rt_rdata),
    .srf_gp_en(srf_gp_en), .srf_gp_we(srf_gp_we),
    .srf_gp_addr(srf_gp_addr), .srf_gp_wdata(srf_gp_wdata),
    .srf_gp_rdata(srf_gp_rdata),
    .conflict_count(conflict_count)
  );

  assign srf_rt_rdata = regs[srf_rt_addr];
  assign srf_gp_rdata = regs[srf_gp_addr];

  always @(posedge clk) begin
    if (srf_rt_en && srf_rt_we) regs[srf_rt_addr] <= srf_rt_wdata;
    if (srf_gp_en && srf_gp_we) regs[srf_gp_addr] <= srf_gp_wdata;
  end

  // Response scoreboard and collision watch.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (srf_rt_en && srf_gp_en && srf_rt_addr == srf_gp_addr &&
          (srf_rt_we || srf_gp_we)) begin
        errors++;
        $display("FAIL collision: addr %0d rt_we %0b gp_we %0b",
                 srf_rt_addr, srf_rt_we, srf_gp_we);
      end
      if (rt_resp_valid) begin
        checks++;
        if (rt_q.size() == 0) begin
          errors++;
          $display("FAIL rt_resp: unexpected response %h",
                   rt_resp_rdata);
        end else begin
          automatic logic [31:0] e = rt_q.pop_front();
          if (rt_resp_rdata !== e) begin
            errors++;
            $display("FAIL rt_resp: got %h expected %h",
                     rt_resp_rdata, e);
          end
        end
      end
      if (gp_resp_valid) begin
        checks++;
        if (gp_q.size() == 0) begin
          errors++;
          $display("FAIL gp_resp: unexpected response %h",
                   gp_resp_rdata);
        end else begin
          automatic logic [31:0] e = gp_q.pop_front();
          if (gp_resp_rdata !== e) begin
            errors++;
            $display("FAIL gp_resp: got %h expected %h",
                     gp_resp_rdata, e);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_rt(input logic v, input logic we,
                        input logic [2:0] a, input logic [31:0] d);
    rt_req_valid = v;
    rt_req_we    = we;
    rt_req_addr  = a;
    rt_req_wdata = d;
  endtask

  task automatic set_gp(input logic v, input logic we,
                        input logic [2:0] a, input logic [31:0] d);
    gp_req_valid = v;
    gp_req_we    = we;
    gp_req_addr  = a;
    gp_req_wdata = d;
  endtask

  task automatic chk_ready(input string nm, input logic ert,
                           input logic egp);
    checks++;
    if (rt_req_ready !== ert || gp_req_ready !== egp) begin
      errors++;
      $display("FAIL %s ready: got rt=%b gp=%b expected rt=%b gp=%b",
               nm, rt_req_ready, gp_req_ready, ert, egp);
    end
  endtask

  task automatic drain(input string nm);
    set_rt(0, 0, 0, 0);
    set_gp(0, 0, 0, 0);
    tick;
    tick;
    checks++;
    if (rt_q.size() != 0 || gp_q.size() != 0) begin
      errors++;
      $display("FAIL %s missing responses: rt %0d gp %0d expected 0 0",
               nm, rt_q.size(), gp_q.size());
      rt_q.delete();
      gp_q.delete();
    end
  endtask

  task automatic chk_cc(input string nm);
    checks++;
    if (conflict_count !== 16'(exp_cc)) begin
      errors++;
      $display("FAIL %s conflict_count: got %0d expected %0d",
               nm, conflict_count, exp_cc);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set_rt(1, 1, 3'd6, 32'hCAFEF00D);
    set_gp(1, 0, 3'd6, 32'h0);
    tick;
    tick;
    checks++;
    if (rt_req_ready !== 0 || gp_req_ready !== 0 ||
        srf_rt_en !== 0 || srf_gp_en !== 0 ||
        srf_rt_we !== 0 || srf_rt_addr !== 0 ||
        srf_rt_wdata !== 0 || srf_gp_addr !== 0 ||
        rt_resp_valid !== 0 || gp_resp_valid !== 0 ||
        rt_resp_rdata !== 0 || gp_resp_rdata !== 0 ||
        conflict_count !== 0) begin
      errors++;
      $display("FAIL reset_outputs: rdy %b%b en %b%b addr %0d cc %0d expected all 0",
               rt_req_ready, gp_req_ready, srf_rt_en, srf_gp_en,
               srf_rt_addr, conflict_count);
    end
    set_rt(0, 0, 0, 0);
    set_gp(0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk_ready("reset_release", 0, 0);
    tick;
    chk_ready("reset_first_edge", 1, 1);
  endtask

  task automatic test_independent;
    set_rt(1, 1, 3'd2, 32'hDEADBEEF);
    set_gp(1, 1, 3'd5, 32'h12345678);
    #1;
    chk_ready("indep_write", 1, 1);
    checks++;
    if (srf_rt_en !== 1 || srf_rt_we !== 1 || srf_rt_addr !== 3'd2 ||
        srf_gp_en !== 1 || srf_gp_we !== 1 || srf_gp_addr !== 3'd5) begin
      errors++;
      $display("FAIL indep_srf: rt %b%b%0d gp %b%b%0d expected 11_2 11_5",
               srf_rt_en, srf_rt_we, srf_rt_addr,
               srf_gp_en, srf_gp_we, srf_gp_addr);
    end
    rt_q.push_back(32'h0);
    gp_q.push_back(32'h0);
    tick;
    set_rt(1, 0, 3'd5, 32'h0);
    set_gp(1, 0, 3'd2, 32'h0);
    #1;
    chk_ready("indep_read", 1, 1);
    rt_q.push_back(32'h12345678);
    gp_q.push_back(32'hDEADBEEF);
    tick;
    drain("indep");
    chk_cc("indep");
  endtask

  task automatic test_conflict;
    set_rt(1, 1, 3'd3, 32'hA5A5A5A5);
    set_gp(1, 0, 3'd3, 32'h0);
    #1;
    chk_ready("conflict_c0", 1, 0);
    checks++;
    if (srf_gp_en !== 0) begin
      errors++;
      $display("FAIL conflict_gp_en: got %b expected 0", srf_gp_en);
    end
    rt_q.push_back(32'h0);
    exp_cc++;
    tick;
    set_rt(0, 0, 0, 0);
    #1;
    chk_ready("conflict_c1", 1, 1);
    gp_q.push_back(32'hA5A5A5A5);
    tick;
    drain("conflict");
    chk_cc("conflict");
  endtask

  // GP holds a read of S1 against a continuous RT write stream.
  task automatic test_starvation;
    logic [31:0] rt_val = 32'h100;
    logic [31:0] last_w = regs[1];
    for (int i = 0; i < 11; i++) begin
      automatic bit gp_win = (i == 4) || (i == 9);
      set_rt(1, 1, 3'd1, rt_val);
      set_gp(i < 10, 0, 3'd1, 32'h0);
      #1;
      if (i < 10) begin
        exp_cc++;
        chk_ready($sformatf("starve_c%0d", i), !gp_win, gp_win);
      end else begin
        chk_ready("starve_tail", 1, 1);
      end
      if (gp_win) begin
        gp_q.push_back(last_w);
      end else begin
        rt_q.push_back(32'h0);
        last_w = rt_val;
        rt_val++;
      end
      tick;
    end
    drain("starve");
    chk_cc("starve");
  endtask

  task automatic test_read_read;
    set_rt(1, 1, 3'd7, 32'h0000FFFF);
    #1;
    rt_q.push_back(32'h0);
    tick;
    set_rt(1, 0, 3'd7, 32'h0);
    set_gp(1, 0, 3'd7, 32'h0);
    #1;
    chk_ready("read_read", 1, 1);
    rt_q.push_back(32'h0000FFFF);
    gp_q.push_back(32'h0000FFFF);
    tick;
    drain("read_read");
    chk_cc("read_read");
  endtask

  task automatic test_mid_reset;
    set_rt(1, 0, 3'd2, 32'h0);
    set_gp(1, 1, 3'd0, 32'h77);
    #1;
    chk_ready("midrst_grant", 1, 1);
    rst_n = 1'b0;
    #1;
    exp_cc = 0;
    chk_cc("midrst_async");
    chk_ready("midrst_async", 0, 0);
    tick;
    checks++;
    if (rt_resp_valid !== 0 || gp_resp_valid !== 0 ||
        rt_resp_rdata !== 0 || gp_resp_rdata !== 0 ||
        srf_rt_en !== 0 || srf_gp_en !== 0) begin
      errors++;
      $display("FAIL midrst_dropped: resp_valid %b%b en %b%b expected 0",
               rt_resp_valid, gp_resp_valid, srf_rt_en, srf_gp_en);
    end
    chk_cc("midrst_held");
    tick;
    set_rt(0, 0, 0, 0);
    set_gp(0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk_ready("midrst_release", 0, 0);
    tick;
    chk_ready("midrst_edge", 1, 1);
    chk_cc("midrst_after");
  endtask

  // Both cores hammer S4 with writes: conflicts every cycle.
  task automatic test_saturation;
    int n = 32'h10005;
    set_rt(1, 1, 3'd4, 32'h11111111);
    set_gp(1, 1, 3'd4, 32'h22222222);
    for (int i = 0; i < n; i++) begin
      automatic bit gp_win = (i % 5) == 4;
      #1;
      chk_ready("sat", !gp_win, gp_win);
      if (gp_win) gp_q.push_back(32'h0);
      else rt_q.push_back(32'h0);
      tick;
      if (i + 1 == 32'hFFFE) begin
        exp_cc = 32'hFFFE;
        chk_cc("sat_fffe");
      end
    end
    exp_cc = 32'hFFFF;
    chk_cc("sat_final");
    drain("sat");
    chk_cc("sat_hold");
  endtask

  initial begin
    for (int i = 0; i < 8; i++) regs[i] = '0;
    rst_n = 1'b0;
    set_rt(0, 0, 0, 0);
    set_gp(0, 0, 0, 0);
    test_reset;
    test_independent;
    test_conflict;
    test_starvation;
    test_read_read;
    test_mid_reset;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
